// File: rtl/vga_chain_source_pkg.sv
// Shared VGA timing constants, FSM state and chain payload type for the
// vga_chain_source head and the Draw_* overlays further down the chain.
package vga_chain_source_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned PXL_W   = 11;
    localparam int unsigned COLOR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } vga_state_t;

    typedef struct packed {
        logic [PXL_W-1:0]   pxl_x;
        logic [PXL_W-1:0]   pxl_y;
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
        logic               en;
        logic               hsync;
        logic               vsync;
        logic               active;
    } vga_chain_t;

    function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga.sv
// Chain link carrying one pixel's position, colour and sync state per clock.
interface vga;
    import vga_chain_source_pkg::*;

    vga_chain_t t;

    modport out (output t);
    modport in  (input  t);
endinterface

// File: rtl/vga_line_counter.sv
// Wrap counter: counts 0..TOTAL-1 while en is high; wrap flags the terminal count.
module vga_line_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(TOTAL - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_chain_source.sv
// Head of the VGA draw chain: generates raster timing and a flat background,
// starting whole frames on request and never truncating a frame in progress.
module vga_chain_source
    import vga_chain_source_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        run,
    input  logic [11:0] bg_color,
    vga.out             vga_chain_out,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);

    vga_state_t     state;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           counting;
    logic           h_wrap;
    logic           last_pixel;
    logic           visible;
    int unsigned    hx;
    int unsigned    vx;
    vga_chain_t     pix;

    assign counting = (state != IDLE);
    assign hx       = 32'(h_cnt);
    assign vx       = 32'(v_cnt);

    vga_line_counter #(.TOTAL(H_TOTAL), .W(H_W)) u_h_cnt (
        .clk    (clk),
        .resetN (resetN),
        .en     (counting),
        .cnt    (h_cnt),
        .wrap   (h_wrap)
    );

    // The vertical wrap is only raised on a horizontal wrap, so it marks the last pixel.
    vga_line_counter #(.TOTAL(V_TOTAL), .W(V_W)) u_v_cnt (
        .clk    (clk),
        .resetN (resetN),
        .en     (h_wrap),
        .cnt    (v_cnt),
        .wrap   (last_pixel)
    );

    // Dropping run on the very last pixel ends cleanly in IDLE rather than
    // entering DRAIN for a whole extra frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (run) state <= RUN;
                RUN:     if (!run) state <= last_pixel ? IDLE : DRAIN;
                DRAIN: begin
                    if (run)             state <= RUN;
                    else if (last_pixel) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign frame_start = counting && (h_cnt == '0) && (v_cnt == '0);
    assign visible     = counting && (hx < H_ACTIVE) && (vx < V_ACTIVE);

    always_comb begin
        pix        = '0;
        pix.pxl_x  = PXL_W'(h_cnt);
        pix.pxl_y  = PXL_W'(v_cnt);
        pix.active = visible;
        pix.en     = 1'b0;
        pix.hsync  = (counting && in_window(hx, H_ACTIVE + H_FP, H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        pix.vsync  = (counting && in_window(vx, V_ACTIVE + V_FP, V_SYNC)) ? SYNC_POL : ~SYNC_POL;
        {pix.red, pix.green, pix.blue} = visible ? bg_color : '0;
    end

    assign vga_chain_out.t = pix;

endmodule

// File: tb/tb_vga_chain_source.sv
// Scoreboard bench: a small-timing instance for frame control and a
// default-timing instance for the 640x480 constants.
module tb_vga_chain_source;
    import vga_chain_source_pkg::*;

    localparam int HT    = 16;
    localparam int VT    = 10;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        resetN;
    logic        rst_def;
    logic        run;
    logic [11:0] bg_color;
    logic        fs_s, fs_d;
    logic [7:0]  fc_s, fc_d;

    int n_checks = 0;
    int n_fail   = 0;

    vga vga_s ();
    vga vga_d ();

    always #5 clk = ~clk;

    vga_chain_source #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .run           (run),
        .bg_color      (bg_color),
        .vga_chain_out (vga_s),
        .frame_start   (fs_s),
        .frame_cnt     (fc_s)
    );

    vga_chain_source dut_def (
        .clk           (clk),
        .resetN        (rst_def),
        .run           (1'b1),
        .bg_color      (bg_color),
        .vga_chain_out (vga_d),
        .frame_start   (fs_d),
        .frame_cnt     (fc_d)
    );

    function automatic logic [46:0] exp_vec(input int x, input int y, input logic busy,
                                            input logic fs, input int fc,
                                            input int ha, input int va, input int hs0,
                                            input int hs1, input int vs0, input int vs1);
        vga_chain_t e;
        e.pxl_x  = 11'(x);
        e.pxl_y  = 11'(y);
        e.active = busy && (x < ha) && (y < va);
        {e.red, e.green, e.blue} = e.active ? bg_color : 12'h000;
        e.en     = 1'b0;
        e.hsync  = !(busy && x >= hs0 && x <= hs1);
        e.vsync  = !(busy && y >= vs0 && y <= vs1);
        return {e, fs, 8'(fc)};
    endfunction

    task automatic check(input string name, input logic [46:0] got, input logic [46:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%h required=%h", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, got, exp);
        end
    endtask

    logic [46:0] q_s[$];
    logic [46:0] q_d[$];
    logic        m_busy;
    int          m_p, m_fc, k_d, cyc;
    int          fs_times[$];

    // Small-timing model: a linear pixel index inside a frame, continuing only at frame end.
    initial begin
        m_busy = 1'b0; m_p = 0; m_fc = 0;
        forever begin
            @(posedge clk);
            if (!resetN) begin
                m_busy = 1'b0; m_p = 0; m_fc = 0;
            end else begin
                if (m_busy && m_p == 0) m_fc = (m_fc + 1) % 256;
                if (!m_busy) begin
                    if (run) begin m_busy = 1'b1; m_p = 0; end
                end else if (m_p == FRAME - 1) begin
                    if (run) m_p = 0;
                    else begin m_busy = 1'b0; m_p = 0; end
                end else begin
                    m_p++;
                end
            end
            q_s.push_back(exp_vec(m_p % HT, m_p / HT, m_busy, m_busy && m_p == 0, m_fc,
                                  8, 6, 10, 12, 7, 8));
        end
    end

    initial begin
        k_d = -1;
        forever begin
            @(posedge clk);
            if (!rst_def) k_d = -1;
            else          k_d++;
            if (k_d < 0)
                q_d.push_back(exp_vec(0, 0, 1'b0, 1'b0, 0, 640, 480, 656, 751, 490, 491));
            else if (k_d < 1700)
                q_d.push_back(exp_vec(k_d % 800, k_d / 800, 1'b1, k_d == 0, (k_d > 0) ? 1 : 0,
                                      640, 480, 656, 751, 490, 491));
        end
    end

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (q_s.size() > 0) check("sb_small", {vga_s.t, fs_s, fc_s}, q_s.pop_front());
            if (q_d.size() > 0) check("sb_default", {vga_d.t, fs_d, fc_d}, q_d.pop_front());
            if (fs_s) fs_times.push_back(cyc);
        end
    end

    task automatic wait_pos(input int fc, input int p, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #2;
            if (m_busy && m_fc == fc && m_p == p) return;
        end
        n_checks++; n_fail++;
        $display("FAIL %s: position fc=%0d p=%0d not reached in %0d cycles", name, fc, p, limit);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #2;
            if (!m_busy) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_idle: frame did not end in %0d cycles", limit);
    endtask

    initial begin
        resetN = 1'b0; rst_def = 1'b0; run = 1'b0; bg_color = 12'h0F0;
        repeat (3) @(negedge clk);
        #2 resetN = 1'b1; rst_def = 1'b1;
        repeat (3) @(negedge clk);
        #2 run = 1'b1;

        wait_pos(3, 3 * HT + 5, 700, "reach_f3");
        check_int("fs_count_run", fs_times.size(), 3);
        if (fs_times.size() >= 3) begin
            check_int("fs_interval_0", fs_times[1] - fs_times[0], FRAME);
            check_int("fs_interval_1", fs_times[2] - fs_times[1], FRAME);
        end
        run = 1'b0;

        wait_idle(200);
        bg_color = 12'hA5C;
        repeat (20) @(negedge clk);
        #2;
        check_int("fs_count_idle", fs_times.size(), 3);
        check_int("frame_cnt_idle", int'(fc_s), 3);

        run = 1'b1;
        wait_pos(4, 4 * HT, 200, "reach_drop");
        run = 1'b0;
        wait_pos(4, 7 * HT, 200, "reach_reraise");
        run = 1'b1;
        wait_pos(5, 1, 200, "reach_f5");
        check_int("fs_count_drain", fs_times.size(), 5);
        if (fs_times.size() >= 5)
            check_int("fs_interval_drain", fs_times[4] - fs_times[3], FRAME);

        wait_pos(5, 4 * HT + 6, 200, "reach_reset");
        resetN = 1'b0;
        run = 1'b0;
        #1;
        check("reset_async", {vga_s.t, fs_s, fc_s},
              exp_vec(0, 0, 1'b0, 1'b0, 0, 8, 6, 10, 12, 7, 8));
        repeat (2) @(negedge clk);
        #2 resetN = 1'b1; run = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_int("frame_cnt_after_reset", int'(fc_s), 1);

        for (int i = 0; i < 2000 && k_d < 1700; i++) @(negedge clk);
        if (k_d < 1700) begin
            n_checks++; n_fail++;
            $display("FAIL default_run: only %0d of 1700 cycles observed", k_d);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_chain_source.md
VGA_CHAIN_SOURCE -- requirements
Module: vga_chain_source

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 1'b0, asserted level of hsync and vsync.
REQ-010 clk  input  1  pixel clock; one pixel per cycle.
REQ-011 resetN  input  1  asynchronous, active-low reset.
REQ-012 run  input  1  level request to generate frames.
REQ-013 bg_color  input  12  background {red, green, blue}, 4 bits each.
REQ-014 vga_chain_out  vga.out  --  chain head: t.pxl_x, t.pxl_y, t.red, t.green, t.blue, t.en, t.hsync, t.vsync, t.active.
REQ-015 frame_start  output  1  one-cycle pulse at pixel (0,0) of each generated frame.
REQ-016 frame_cnt  output  8  count of frames started, modulo 256.

Function
REQ-017 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 800 by default; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 525 by default.
REQ-018 Counter widths: h_cnt is $clog2(H_TOTAL) bits and v_cnt is $clog2(V_TOTAL) bits, both unsigned.
REQ-019 t.pxl_x and t.pxl_y are zero-extended into the chain field widths.
REQ-020 The FSM has states IDLE, RUN and DRAIN.
REQ-021 IDLE transitions to RUN on the first cycle run=1.
REQ-022 RUN transitions to DRAIN when run=0.
REQ-023 DRAIN transitions to RUN if run returns to 1 before the frame end; otherwise it goes to IDLE when the last pixel (H_TOTAL-1, V_TOTAL-1) completes.
REQ-024 In RUN and DRAIN, h_cnt increments every cycle.
REQ-025 h_cnt wraps from H_TOTAL-1 to 0, and on that wrap v_cnt increments.
REQ-026 v_cnt wraps from V_TOTAL-1 to 0.
REQ-027 In IDLE: h_cnt=v_cnt=0, active=0, syncs deasserted, and frame_start=0.
REQ-028 t.pxl_x = h_cnt and t.pxl_y = v_cnt (registered), including in the blanking region.
REQ-029 t.active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE) && state != IDLE.
REQ-030 t.hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise it is ~SYNC_POL.
REQ-031 t.vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise it is ~SYNC_POL.
REQ-032 {t.red, t.green, t.blue} = bg_color when t.active=1, else 12'h000.
REQ-033 t.en = 0 always, since the chain head draws no object.
REQ-034 frame_start = 1 in exactly the cycle where h_cnt=0, v_cnt=0 and the state is RUN or DRAIN-continuing.
REQ-035 frame_cnt increments in that same cycle and wraps 255 to 0.
REQ-036 The first frame after IDLE->RUN presents (0,0) in the first cycle after run is sampled high, i.e. a latency of 1 clock.
REQ-037 run toggling mid-frame never truncates or restarts a frame; a frame always finishes all V_TOTAL lines.

Reset
REQ-038 While resetN=0: state=IDLE, h_cnt=0, v_cnt=0, frame_cnt=0, frame_start=0, active=0, hsync=vsync=~SYNC_POL, colors=0, en=0.
REQ-039 Reset asserted mid-frame takes effect immediately (asynchronously), and the block restarts from IDLE after deassertion.

Structure
REQ-040 A shared package holds the default VGA timing constants (H/V active, porches, sync widths, totals) and the state enum; Draw_* overlays use the same constants.
REQ-041 One sub-module is natural: vga_line_counter, a parameterised wrap counter with wrap-pulse output, instantiated for h and v.

Verification
REQ-042 Reset then run=1 held: pxl_x goes 0..799 and wraps; pxl_y increments at each wrap; frame_start pulses every 420000 clocks; frame_cnt=1 after the first pulse.
REQ-043 Default timing: hsync=0 exactly for h_cnt 656..751; vsync=0 exactly for v_cnt 490..491; active=1 only for h<640 and v<480.
REQ-044 bg_color=12'h0F0: colors=12'h0F0 at (639,479) and 12'h000 at (640,479) and at (0,480); en=0 throughout.
REQ-045 run dropped at (100,200): counting continues to (799,524), then holds at (0,0) in IDLE with frame_start=0 and no frame_cnt change.
REQ-046 run re-raised at line 300 during DRAIN: no stall; next frame_start occurs at the normal frame boundary.
REQ-047 resetN pulsed low at (400,300): all outputs go to reset values immediately; after release with run=1, frame_start occurs 1 cycle later and frame_cnt=1.
